multicore_bus_arbiter: RTL and testbench
========================================

# multicore_bus_arbiter

Parametrised N-core snooping-bus arbiter and interconnect for the multicore cache system. Grants the shared coherence bus to one core at a time via round-robin, with flush requests prioritised. While a core owns the bus, it broadcasts that core's bus transaction to all other cores as a snoop and returns their combined hit to the owner. It also steers the owner's address, data and opcode to the L2 cache subsystem.

## Interface
Parameters:
- NUM_CORES, 4: number of requesting cores, 2..8.
- DATA_W, 32: bus data width.
- ADDR_W, 32: bus address width.
- MAX_HOLD, 16: cycles a core may hold the grant before forced release (timeout feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_core  in  NUM_CORES  per-core bus request, level, held until done.
- flush_in  in  NUM_CORES  per-core flush qualifier; raises that core's request to high priority.
- bus_operation_in  in  NUM_CORES×2  per-core bus operation (bus_pkg::bus_op_t).
- bus_address_in  in  NUM_CORES×ADDR_W  per-core bus address.
- bus_data_in  in  NUM_CORES×DATA_W  per-core bus data.
- data_to_L2_in  in  NUM_CORES×DATA_W  per-core write-back data for L2.
- opcode_in  in  NUM_CORES×7  per-core instruction opcode.
- cache_hit_in  in  NUM_CORES  per-core snoop hit response.
- data_from_L2  in  DATA_W  L2 read data.
- grant  out  NUM_CORES  one-hot or zero bus grant, registered.
- bus_operation_out / bus_address_out / bus_data_out  out  2 / ADDR_W / DATA_W  broadcast snoop transaction.
- snoop_valid  out  NUM_CORES  snoop strobe: every core except the owner.
- cache_hit_out  out  NUM_CORES  to owner: OR of the other cores' cache_hit_in; 0 to all others.
- address_to_L2 / data_to_L2 / opcode_out  out  ADDR_W / DATA_W / 7  owner's values steered to L2.
- bus_data_to_owner  out  DATA_W  data_from_L2 when no snooper hit, else bus_data_in of the lowest-index hitting snooper.
- timeout_err  out  1  one-cycle pulse on forced release (timeout feature only).

## Operation
- FSM states:
  - IDLE: on any req_core, choose a winner and go to OWN.
  - OWN: stay while the owner's req_core is high. Go to RELEASE when it drops.
  - RELEASE: one dead cycle, grant = 0, then IDLE.
- Winner selection:
  - Requests with flush_in set form the high class. If any exist, only the high class competes.
  - Within a class, round-robin starting at rr_ptr + 1 (mod NUM_CORES).
  - On grant, rr_ptr ← winner index.
- Requests from non-owners during OWN/RELEASE are ignored until IDLE. Cores must hold them.
- With grant = 0 (IDLE/RELEASE), all bus outputs behave as follows:
  - bus_operation_out = BUS_NONE (2'b00).
  - Address, data and opcode outputs = 0.
  - snoop_valid = 0, cache_hit_out = 0.
- In OWN, bus outputs are the owner's inputs, muxed by the registered grant (combinational path).
  - snoop_valid = ~grant.
- BUS_NONE from the owner: snoop_valid is forced to 0, and the owner keeps the grant.
- Reset values: grant 0, rr_ptr NUM_CORES-1 (so core 0 wins first), state IDLE, timeout_err 0, all bus outputs 0.
- Reset mid-OWN: grant drops immediately (asynchronous). Any in-flight transaction is abandoned.

## Timing
- Request sampled in IDLE at edge t → grant asserted after edge t (visible in cycle t+1).
- Owner drops req_core in cycle k → grant low from cycle k+1 (RELEASE) → next grant visible at earliest cycle k+3.
- Snoop broadcast, cache_hit_out and bus_data_to_owner are combinational within the owning cycle. There is no added latency.
- Simultaneous flush and plain requests in IDLE: the flush requester wins regardless of rr_ptr.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A hold counter clears on entry to OWN and increments each OWN cycle.
  - When it reaches MAX_HOLD-1 while req_core is still high, the FSM goes to RELEASE and timeout_err pulses for one cycle.
  - The core loses the grant and may re-request.
- Undefined: no counter. timeout_err is tied 0. Ownership is unbounded.

## Structure
- Package bus_pkg holds:
  - bus_op_t enum: BUS_NONE=0, BUS_RD=1, BUS_RDX=2, BUS_UPGR=3.
  - arb_state_t enum: IDLE, OWN, RELEASE.
  - OPCODE_W=7.
- Sub-module rr_arbiter(N) is combinational. Inputs: request vector, pointer. Outputs: one-hot grant and its index. It is instantiated twice (high class and normal class).

## Test plan
- Reset, then req_core=4'b0101 → grant=0001 (core 0). Drop req0 → RELEASE → grant=0100 (core 2).
- All four request continuously and each drops after 3 cycles → grant order 0,1,2,3,0.
- req_core=1111, flush_in=1000, rr_ptr=0 → grant=1000.
- Core 1 owns with BUS_RD at 0x100 and core 3 has cache_hit_in=1 → snoop_valid=1101, cache_hit_out=0010, bus_data_to_owner = core 3's bus_data_in.
- Core 1 owns with no snooper hit and data_from_L2=0xDEADBEEF → bus_data_to_owner=0xDEADBEEF, address_to_L2 = core 1's address.
- With BUS_ARB_TIMEOUT_EN and MAX_HOLD=16, core 0 holds req → grant drops after 16 OWN cycles, timeout_err pulses once. Assert reset mid-OWN → grant=0 without waiting for a clock edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the snooping-bus arbiter: bus operations, arbiter FSM states
// and the instruction opcode width.
package bus_pkg;

  localparam int OPCODE_W = 7;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_RDX  = 2'd2,
    BUS_UPGR = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req starting one past ptr and returns
// the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int   c;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/multicore_bus_arbiter.sv
// N-core snooping-bus arbiter: flush-first round-robin grant, snoop broadcast
// and L2 steering. Define BUS_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module multicore_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_HOLD  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_core,
  input  logic [NUM_CORES-1:0]          flush_in,
  input  logic [NUM_CORES*2-1:0]        bus_operation_in,
  input  logic [NUM_CORES*ADDR_W-1:0]   bus_address_in,
  input  logic [NUM_CORES*DATA_W-1:0]   bus_data_in,
  input  logic [NUM_CORES*DATA_W-1:0]   data_to_L2_in,
  input  logic [NUM_CORES*OPCODE_W-1:0] opcode_in,
  input  logic [NUM_CORES-1:0]          cache_hit_in,
  input  logic [DATA_W-1:0]             data_from_L2,
  output logic [NUM_CORES-1:0]          grant,
  output bus_op_t                       bus_operation_out,
  output logic [ADDR_W-1:0]             bus_address_out,
  output logic [DATA_W-1:0]             bus_data_out,
  output logic [NUM_CORES-1:0]          snoop_valid,
  output logic [NUM_CORES-1:0]          cache_hit_out,
  output logic [ADDR_W-1:0]             address_to_L2,
  output logic [DATA_W-1:0]             data_to_L2,
  output logic [OPCODE_W-1:0]           opcode_out,
  output logic [DATA_W-1:0]             bus_data_to_owner,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_CORES);

  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] hi_gnt, lo_gnt, snoop_hits;
  logic [IDX_W-1:0]     hi_idx, lo_idx;
  logic                 hi_any, lo_any, hold_expire;
  int                   o;

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr_hi (
    .req(req_core & flush_in), .ptr(rr_ptr), .gnt(hi_gnt), .idx(hi_idx), .any(hi_any)
  );

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr_lo (
    .req(req_core), .ptr(rr_ptr), .gnt(lo_gnt), .idx(lo_idx), .any(lo_any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  assign hold_expire = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  // MAX_HOLD is meaningless without the timeout; this is constant false.
  assign hold_expire = (MAX_HOLD == 0);
  assign timeout_err = 1'b0;
`endif

  // rr_ptr doubles as the owner index while in OWN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= IDX_W'(NUM_CORES - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (lo_any) begin
            state  <= OWN;
            grant  <= hi_any ? hi_gnt : lo_gnt;
            rr_ptr <= hi_any ? hi_idx : lo_idx;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        OWN: begin
          if (!req_core[rr_ptr] || hold_expire) begin
            state <= RELEASE;
            grant <= '0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          hold_cnt    <= hold_cnt + 1'b1;
          timeout_err <= req_core[rr_ptr] && hold_expire;
`endif
        end
        RELEASE: begin
          state <= IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- combinational owner mux, snoop broadcast and hit return ----
  always_comb begin
    o                 = int'(rr_ptr);
    bus_operation_out = BUS_NONE;
    bus_address_out   = '0;
    bus_data_out      = '0;
    snoop_valid       = '0;
    snoop_hits        = '0;
    cache_hit_out     = '0;
    address_to_L2     = '0;
    data_to_L2        = '0;
    opcode_out        = '0;
    bus_data_to_owner = '0;
    if (|grant) begin
      bus_operation_out = bus_op_t'(bus_operation_in[o*2 +: 2]);
      bus_address_out   = bus_address_in[o*ADDR_W +: ADDR_W];
      bus_data_out      = bus_data_in[o*DATA_W +: DATA_W];
      address_to_L2     = bus_address_in[o*ADDR_W +: ADDR_W];
      data_to_L2        = data_to_L2_in[o*DATA_W +: DATA_W];
      opcode_out        = opcode_in[o*OPCODE_W +: OPCODE_W];
      snoop_valid       = (bus_operation_out == BUS_NONE) ? '0 : ~grant;
      snoop_hits        = cache_hit_in & ~grant;
      cache_hit_out     = (|snoop_hits) ? grant : '0;
      bus_data_to_owner = data_from_L2;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (snoop_hits[i]) bus_data_to_owner = bus_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_multicore_bus_arbiter.sv
// Self-checking bench for multicore_bus_arbiter: directed scenarios plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_multicore_bus_arbiter;
  import bus_pkg::*;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MH = 16;
  localparam int OW = 7;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    req_core, flush_in, cache_hit_in;
  logic [NC*2-1:0]  bus_operation_in;
  logic [NC*AW-1:0] bus_address_in;
  logic [NC*DW-1:0] bus_data_in, data_to_L2_in;
  logic [NC*OW-1:0] opcode_in;
  logic [DW-1:0]    data_from_L2;
  logic [NC-1:0]    grant, snoop_valid, cache_hit_out;
  logic [1:0]       bus_operation_out;
  logic [AW-1:0]    bus_address_out, address_to_L2;
  logic [DW-1:0]    bus_data_out, data_to_L2, bus_data_to_owner;
  logic [OW-1:0]    opcode_out;
  logic             timeout_err;

  multicore_bus_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req_core(req_core), .flush_in(flush_in),
    .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in), .data_to_L2_in(data_to_L2_in), .opcode_in(opcode_in),
    .cache_hit_in(cache_hit_in), .data_from_L2(data_from_L2), .grant(grant),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .snoop_valid(snoop_valid), .cache_hit_out(cache_hit_out),
    .address_to_L2(address_to_L2), .data_to_L2(data_to_L2), .opcode_out(opcode_out),
    .bus_data_to_owner(bus_data_to_owner), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, whether we sit in the dead cycle,
  // the last winner and how long the current owner has held the bus.
  bit m_owning, m_dead, m_terr;
  int m_owner, m_last, m_hold;

  function automatic int pick(input logic [NC-1:0] r, input logic [NC-1:0] f, input int last);
    logic [NC-1:0] cand;
    cand = ((r & f) != 0) ? (r & f) : r;
    for (int k = 1; k <= NC; k++)
      if (cand[(last + k) % NC]) return (last + k) % NC;
    return -1;
  endfunction

  task automatic model_reset();
    m_owning = 0; m_dead = 0; m_terr = 0; m_owner = 0; m_last = NC - 1; m_hold = 0;
  endtask

  task automatic model_edge();
    m_terr = 0;
    if (m_dead) begin
      m_dead = 0;
    end else if (m_owning) begin
      if (!req_core[m_owner]) begin
        m_owning = 0; m_dead = 1;
      end else if (TO_EN && m_hold == MH - 1) begin
        m_owning = 0; m_dead = 1; m_terr = 1;
      end else begin
        m_hold++;
      end
    end else if (req_core != 0) begin
      m_owner  = pick(req_core, flush_in, m_last);
      m_last   = m_owner;
      m_owning = 1;
      m_hold   = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NC-1:0] eg, esv, ech, hits;
    logic [1:0]    eop;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, el2, eown;
    logic [OW-1:0] eopc;
    eg = '0; esv = '0; ech = '0; eop = 2'd0; ea = '0; ed = '0; el2 = '0; eown = '0; eopc = '0;
    if (m_owning) begin
      eg   = NC'(1) << m_owner;
      eop  = bus_operation_in[m_owner*2 +: 2];
      ea   = bus_address_in[m_owner*AW +: AW];
      ed   = bus_data_in[m_owner*DW +: DW];
      el2  = data_to_L2_in[m_owner*DW +: DW];
      eopc = opcode_in[m_owner*OW +: OW];
      esv  = (eop == 2'd0) ? '0 : ~eg;
      hits = cache_hit_in & ~eg;
      ech  = (hits != 0) ? eg : '0;
      eown = data_from_L2;
      for (int i = 0; i < NC; i++) begin
        if (hits[i]) begin
          eown = bus_data_in[i*DW +: DW];
          break;
        end
      end
    end
    check({tag, ".grant"}, grant, eg);
    check({tag, ".timeout_err"}, timeout_err, m_terr);
    check({tag, ".bus_op"}, bus_operation_out, eop);
    check({tag, ".bus_addr"}, bus_address_out, ea);
    check({tag, ".bus_data"}, bus_data_out, ed);
    check({tag, ".snoop_valid"}, snoop_valid, esv);
    check({tag, ".cache_hit_out"}, cache_hit_out, ech);
    check({tag, ".addr_l2"}, address_to_L2, ea);
    check({tag, ".data_l2"}, data_to_L2, el2);
    check({tag, ".opcode"}, opcode_out, eopc);
    check({tag, ".data_owner"}, bus_data_to_owner, eown);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    req_core = '0; flush_in = '0; cache_hit_in = '0; bus_operation_in = '0;
    bus_address_in = '0; bus_data_in = '0; data_to_L2_in = '0; opcode_in = '0;
    data_from_L2 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int order [5];
    int n, owned, pulses;
    order = '{0, 1, 2, 3, 0};

    clear_inputs();
    do_reset();

    // two requesters: core 0 first, then core 2 after the dead cycle
    req_core = 4'b0101;
    tick("two_req");
    check("two_req.first", grant, 4'b0001);
    req_core = 4'b0100;
    tick("drop0");
    check("drop0.release", grant, 4'b0000);
    tick("drop0_idle");
    tick("second");
    check("two_req.second", grant, 4'b0100);
    req_core = '0;
    tick("idle_a");
    tick("idle_b");

    // round-robin order with every core requesting
    do_reset();
    req_core = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!m_owning && n < 8) begin
        tick("rr_wait");
        n++;
      end
      check("rr_order", grant, 4'(1) << order[g]);
      tick("rr_hold1");
      tick("rr_hold2");
      req_core[m_owner] = 1'b0;
      tick("rr_drop");
      req_core = 4'b1111;
    end

    // flush class beats round-robin position
    clear_inputs();
    do_reset();
    req_core = 4'b0001;
    tick("fl_own0");
    req_core = 4'b1110; flush_in = 4'b1000;
    tick("fl_rel");
    req_core = 4'b1111;
    tick("fl_idle");
    tick("fl_grant");
    check("flush.win", grant, 4'b1000);

    // snoop broadcast with a hit from core 3
    clear_inputs();
    do_reset();
    req_core = 4'b0010;
    bus_operation_in[2 +: 2] = 2'd1;
    bus_address_in[AW +: AW] = 32'h100;
    bus_data_in[3*DW +: DW]  = 32'hCAFE_F00D;
    bus_data_in[DW +: DW]    = 32'h1111_2222;
    cache_hit_in             = 4'b1000;
    data_from_L2             = 32'h0BAD_0BAD;
    tick("snoop");
    check("snoop.grant", grant, 4'b0010);
    check("snoop.valid", snoop_valid, 4'b1101);
    check("snoop.hit_out", cache_hit_out, 4'b0010);
    check("snoop.owner_data", bus_data_to_owner, 32'hCAFE_F00D);
    cache_hit_in = 4'b0000; data_from_L2 = 32'hDEAD_BEEF;
    #1;
    check("l2.owner_data", bus_data_to_owner, 32'hDEAD_BEEF);
    check("l2.addr", address_to_L2, 32'h100);
    check("l2.hit_out", cache_hit_out, 4'b0000);
    bus_operation_in[2 +: 2] = 2'd0;
    #1;
    check("none.snoop_valid", snoop_valid, 4'b0000);
    tick("none_keep");
    check("none.grant_kept", grant, 4'b0010);

`ifdef BUS_ARB_TIMEOUT_EN
    // forced release after MAX_HOLD owning cycles
    clear_inputs();
    do_reset();
    req_core = 4'b0001;
    owned = 0; pulses = 0; n = 0;
    tick("to_start");
    while (grant == 4'b0001 && n < 40) begin
      owned++;
      n++;
      tick("to_hold");
    end
    check("timeout.owned_cycles", owned, MH);
    check("timeout.pulse", timeout_err, 1'b1);
    tick("to_after");
    check("timeout.pulse_end", timeout_err, 1'b0);
    pulses = 0;
`endif

    // asynchronous reset while a core owns the bus
    clear_inputs();
    do_reset();
    req_core = 4'b0001;
    tick("ar_own");
    check("ar.owned", grant, 4'b0001);
    #3;
    reset = 1'b1;
    #1;
    check("ar.grant_async", grant, 4'b0000);
    model_reset();
    check_outputs("ar");
    @(negedge clk);
    reset = 1'b0;

    // random traffic against the model
    clear_inputs();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (m_owning && i == m_owner) begin
          if ($urandom_range(3) == 0) req_core[i] = 1'b0;
        end else if (!req_core[i]) begin
          req_core[i] = ($urandom_range(2) == 0);
        end
      end
      flush_in         = NC'($urandom_range(15)) & NC'($urandom_range(15));
      cache_hit_in     = NC'($urandom_range(15));
      bus_operation_in = 8'($urandom);
      bus_address_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_data_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
      data_to_L2_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      opcode_in        = 28'($urandom);
      data_from_L2     = $urandom();
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
